// File: rtl/sys_cmd_decoder.sv
// Host command-frame parser driving register-file/ALU strobes; optional frame timeout under CMD_TIMEOUT_EN.
// Latency: one cycle from accepted byte to registered outputs; bytes are dropped while a response is outstanding (busy).
module sys_cmd_decoder #(
  parameter int              DATA_WIDTH     = 8,
  parameter int              ADDR_WIDTH     = 4,
  parameter int              FUN_WIDTH      = 4,
  parameter logic [15:0]     TIMEOUT_CYCLES = 16'd50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  resp_done,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  alu_en,
  output logic [FUN_WIDTH-1:0]  alu_fun,
  output logic                  clk_gate_en,
  output logic                  cmd_err,
  output logic                  busy
);

  localparam logic [DATA_WIDTH-1:0] OP_WR      = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD      = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU     = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_ALU_NOP = DATA_WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_OPA, S_OPB, S_ALU_FUN, S_WAIT_RESP
  } state_t;

  state_t state;

`ifdef CMD_TIMEOUT_EN
  logic [15:0] idle_cnt;
`else
  // The timeout limit has no effect in this build.
  localparam logic [15:0] UNUSED_TIMEOUT = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      rf_wr_en    <= 1'b0;
      rf_rd_en    <= 1'b0;
      rf_addr     <= '0;
      rf_wr_data  <= '0;
      alu_en      <= 1'b0;
      alu_fun     <= '0;
      clk_gate_en <= 1'b0;
      cmd_err     <= 1'b0;
      busy        <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      idle_cnt    <= '0;
`endif
    end else begin
      rf_wr_en <= 1'b0;
      rf_rd_en <= 1'b0;
      alu_en   <= 1'b0;
      cmd_err  <= 1'b0;
      // resp_done takes priority over any byte arriving while a response is pending.
      if (state == S_WAIT_RESP) begin
        if (resp_done) begin
          state       <= S_IDLE;
          busy        <= 1'b0;
          clk_gate_en <= 1'b0;
        end
      end else if (rx_valid) begin
`ifdef CMD_TIMEOUT_EN
        idle_cnt <= '0;
`endif
        case (state)
          S_IDLE: begin
            if (rx_data == OP_WR)          state <= S_WR_ADDR;
            else if (rx_data == OP_RD)     state <= S_RD_ADDR;
            else if (rx_data == OP_ALU)    state <= S_OPA;
            else if (rx_data == OP_ALU_NOP) begin
              state       <= S_ALU_FUN;
              clk_gate_en <= 1'b1;
            end else                       cmd_err <= 1'b1;
          end
          S_WR_ADDR: begin
            rf_addr <= rx_data[ADDR_WIDTH-1:0];
            state   <= S_WR_DATA;
          end
          S_WR_DATA: begin
            rf_wr_data <= rx_data;
            rf_wr_en   <= 1'b1;
            state      <= S_IDLE;
          end
          S_RD_ADDR: begin
            rf_addr  <= rx_data[ADDR_WIDTH-1:0];
            rf_rd_en <= 1'b1;
            busy     <= 1'b1;
            state    <= S_WAIT_RESP;
          end
          S_OPA: begin
            rf_addr    <= '0;
            rf_wr_data <= rx_data;
            rf_wr_en   <= 1'b1;
            state      <= S_OPB;
          end
          S_OPB: begin
            rf_addr     <= ADDR_WIDTH'(1);
            rf_wr_data  <= rx_data;
            rf_wr_en    <= 1'b1;
            clk_gate_en <= 1'b1;
            state       <= S_ALU_FUN;
          end
          S_ALU_FUN: begin
            alu_fun <= rx_data[FUN_WIDTH-1:0];
            alu_en  <= 1'b1;
            busy    <= 1'b1;
            state   <= S_WAIT_RESP;
          end
          default: state <= S_IDLE;
        endcase
      end
`ifdef CMD_TIMEOUT_EN
      else if (state != S_IDLE) begin
        if (idle_cnt == TIMEOUT_CYCLES) begin
          state       <= S_IDLE;
          cmd_err     <= 1'b1;
          clk_gate_en <= 1'b0;
          idle_cnt    <= '0;
        end else begin
          idle_cnt <= idle_cnt + 16'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_sys_cmd_decoder.sv
// Bench for sys_cmd_decoder: frame-level reference model checked every cycle, plus directed literal checks.
module tb_sys_cmd_decoder;
  localparam int T = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       resp_done = 1'b0;
  logic       rf_wr_en, rf_rd_en, alu_en, clk_gate_en, cmd_err, busy;
  logic [3:0] rf_addr, alu_fun;
  logic [7:0] rf_wr_data;

  sys_cmd_decoder #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4), .TIMEOUT_CYCLES(16'(T))
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .resp_done(resp_done),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr), .rf_wr_data(rf_wr_data),
    .alu_en(alu_en), .alu_fun(alu_fun), .clk_gate_en(clk_gate_en), .cmd_err(cmd_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: the bytes of the frame collected so far, and whether a response is owed.
  logic [7:0] frame[$];
  bit         waiting;
  int         idle_cycles;
  logic       exp_wr, exp_rd, exp_alu, exp_err, exp_busy, exp_gate;
  logic [3:0] exp_addr, exp_fun;
  logic [7:0] exp_wdata;

  task automatic model_byte(input logic [7:0] b);
    int n;
    frame.push_back(b);
    n = frame.size();
    case (frame[0])
      8'hAA: begin
        if (n == 2) exp_addr = b[3:0];
        if (n == 3) begin exp_wdata = b; exp_wr = 1; frame.delete(); end
      end
      8'hBB: begin
        if (n == 2) begin
          exp_addr = b[3:0]; exp_rd = 1; exp_busy = 1; waiting = 1; frame.delete();
        end
      end
      8'hCC: begin
        if (n == 2) begin exp_addr = 4'd0; exp_wdata = b; exp_wr = 1; end
        if (n == 3) begin exp_addr = 4'd1; exp_wdata = b; exp_wr = 1; exp_gate = 1; end
        if (n == 4) begin
          exp_fun = b[3:0]; exp_alu = 1; exp_busy = 1; waiting = 1; frame.delete();
        end
      end
      8'hDD: begin
        if (n == 1) exp_gate = 1;
        if (n == 2) begin
          exp_fun = b[3:0]; exp_alu = 1; exp_busy = 1; waiting = 1; frame.delete();
        end
      end
      default: begin exp_err = 1; frame.delete(); end
    endcase
  endtask

  always @(posedge clk) begin
    exp_wr = 0; exp_rd = 0; exp_alu = 0; exp_err = 0;
    if (!rst) begin
      frame.delete(); waiting = 0; idle_cycles = 0;
      exp_busy = 0; exp_gate = 0; exp_addr = 0; exp_fun = 0; exp_wdata = 0;
    end else if (waiting) begin
      if (resp_done) begin waiting = 0; exp_busy = 0; exp_gate = 0; end
    end else if (rx_valid) begin
      idle_cycles = 0;
      model_byte(rx_data);
    end
`ifdef CMD_TIMEOUT_EN
    else if (frame.size() > 0) begin
      idle_cycles++;
      if (idle_cycles > T) begin
        exp_err = 1; exp_gate = 0; frame.delete(); idle_cycles = 0;
      end
    end
`endif
    #1;
    chk("cyc_rf_wr_en", rf_wr_en, exp_wr);
    chk("cyc_rf_rd_en", rf_rd_en, exp_rd);
    chk("cyc_alu_en", alu_en, exp_alu);
    chk("cyc_cmd_err", cmd_err, exp_err);
    chk("cyc_busy", busy, exp_busy);
    chk("cyc_clk_gate_en", clk_gate_en, exp_gate);
    chk("cyc_rf_addr", rf_addr, exp_addr);
    chk("cyc_rf_wr_data", rf_wr_data, exp_wdata);
    chk("cyc_alu_fun", alu_fun, exp_fun);
  end

  task automatic step(input logic v, input logic [7:0] b, input logic rd);
    @(negedge clk);
    rx_valid = v; rx_data = b; resp_done = rd;
    @(posedge clk);
    #2;
    rx_valid = 0; resp_done = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    bit         seen;
    @(posedge clk); #2;
    chk("reset_rf_addr", rf_addr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_gate", clk_gate_en, 0);
    @(negedge clk); rst = 1;

    // write then read
    step(1, 8'hAA, 0); step(1, 8'h0A, 0); step(1, 8'h89, 0);
    chk("wr_en", rf_wr_en, 1); chk("wr_addr", rf_addr, 4'hA); chk("wr_data", rf_wr_data, 8'h89);
    chk("pin_model_wdata", exp_wdata, 8'h89);
    step(1, 8'hBB, 0); step(1, 8'h0A, 0);
    chk("rd_en", rf_rd_en, 1); chk("rd_addr", rf_addr, 4'hA); chk("rd_busy", busy, 1);
    step(0, 8'h00, 0); chk("rd_busy_hold", busy, 1);
    step(0, 8'h00, 1); chk("rd_busy_fall", busy, 0);

    // ALU with operands
    step(1, 8'hCC, 0); step(1, 8'hFF, 0);
    chk("opa_wr", rf_wr_en, 1); chk("opa_addr", rf_addr, 0); chk("opa_data", rf_wr_data, 8'hFF);
    step(1, 8'hAA, 0);
    chk("opb_wr", rf_wr_en, 1); chk("opb_addr", rf_addr, 1); chk("opb_data", rf_wr_data, 8'hAA);
    chk("opb_gate", clk_gate_en, 1);
    step(1, 8'h04, 0);
    chk("alu_en", alu_en, 1); chk("alu_fun", alu_fun, 4); chk("alu_gate", clk_gate_en, 1);
    chk("pin_model_fun", exp_fun, 4);
    step(0, 8'h00, 0); chk("wait_gate", clk_gate_en, 1);
    step(0, 8'h00, 1); chk("resp_gate_off", clk_gate_en, 0);

    // ALU without operands
    step(1, 8'hDD, 0); chk("dd_gate", clk_gate_en, 1); chk("dd_no_wr", rf_wr_en, 0);
    step(1, 8'h02, 0); chk("dd_alu", alu_en, 1); chk("dd_fun", alu_fun, 2); chk("dd_no_wr2", rf_wr_en, 0);
    step(0, 8'h00, 1);

    // unknown byte, dropped byte, resp_done vs rx_valid collision
    step(1, 8'h55, 0);
    chk("unk_err", cmd_err, 1); chk("unk_strobes", {rf_wr_en, rf_rd_en, alu_en}, 0);
    chk("unk_busy", busy, 0);
    step(1, 8'hBB, 0); step(1, 8'h03, 0);
    step(1, 8'h01, 0);
    chk("drop_quiet", {rf_wr_en, rf_rd_en, alu_en, cmd_err}, 0); chk("drop_busy", busy, 1);
    step(1, 8'h09, 1);
    chk("collide_busy", busy, 0); chk("collide_err", cmd_err, 0);
    step(1, 8'hDD, 0); step(1, 8'h01, 0);
    chk("after_drop_alu", alu_en, 1); chk("after_drop_fun", alu_fun, 1);
    step(0, 8'h00, 1);

    // reset mid-frame
    step(1, 8'hAA, 0); step(1, 8'h03, 0);
    do_reset();
    step(1, 8'h77, 0);
    chk("rst_mid_err", cmd_err, 1); chk("rst_mid_no_wr", rf_wr_en, 0);

`ifdef CMD_TIMEOUT_EN
    step(1, 8'hCC, 0);
    seen = 0;
    for (int i = 0; i < 3 * T && !seen; i++) begin
      step(0, 8'h00, 0);
      if (cmd_err) seen = 1;
    end
    chk("timeout_err_seen", seen, 1);
    step(1, 8'hBB, 0); step(1, 8'h05, 0);
    chk("timeout_then_rd", rf_rd_en, 1); chk("timeout_then_addr", rf_addr, 5);
    step(0, 8'h00, 1);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom % 8)
        0: b = 8'hAA;
        1: b = 8'hBB;
        2: b = 8'hCC;
        3: b = 8'hDD;
        default: b = 8'($urandom);
      endcase
      if ($urandom % 600 == 0) do_reset();
      step(1'($urandom % 2), b, 1'($urandom % 6 == 0));
    end

    @(posedge clk); #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sys_cmd_decoder.md
# sys_cmd_decoder

Command-frame decoder in the reference-clock domain. It consumes the byte stream delivered by the UART receiver, after that stream has been synchronized into the reference domain. It parses the four host commands and drives the register-file and ALU control strobes. While a read or ALU result is being returned through the TX path, it holds off further command parsing.

## Interface
Parameters:
- DATA_WIDTH, 8, byte width of RX data, register data and operands
- ADDR_WIDTH, 4, register-file address width
- FUN_WIDTH, 4, ALU function code width
- TIMEOUT_CYCLES, 16'd50000, idle-cycle limit inside a partial frame (used only with CMD_TIMEOUT_EN)

Ports:
- clk  in  1  reference clock; reset is asynchronous and active-low
- rst  in  1  asynchronous active-low reset
- rx_data  in  DATA_WIDTH  received byte, valid only with rx_valid
- rx_valid  in  1  one-cycle pulse per received byte
- resp_done  in  1  one-cycle pulse: response for the outstanding read/ALU command has been queued to TX
- rf_wr_en  out  1  one-cycle register-file write strobe
- rf_rd_en  out  1  one-cycle register-file read strobe
- rf_addr  out  ADDR_WIDTH  register-file address
- rf_wr_data  out  DATA_WIDTH  register-file write data
- alu_en  out  1  one-cycle ALU start strobe
- alu_fun  out  FUN_WIDTH  ALU function code
- clk_gate_en  out  1  ALU clock-gate enable
- cmd_err  out  1  one-cycle pulse: unknown command byte or frame timeout
- busy  out  1  high in WAIT_RESP

## Operation
- Opcodes: 0xAA reg write (addr, data); 0xBB reg read (addr); 0xCC ALU with operands (OP_A, OP_B, FUN); 0xDD ALU without operands (FUN).
- States and byte transitions (rx_valid):
  - IDLE: 0xAA→WR_ADDR, 0xBB→RD_ADDR, 0xCC→OPA, 0xDD→ALU_FUN. Any other byte stays in IDLE and pulses cmd_err.
  - WR_ADDR: latch rf_addr = byte[ADDR_WIDTH-1:0], upper bits ignored → WR_DATA.
  - WR_DATA: rf_wr_data = byte, rf_wr_en pulse → IDLE.
  - RD_ADDR: rf_addr = byte[ADDR_WIDTH-1:0], rf_rd_en pulse → WAIT_RESP.
  - OPA: rf_wr_en to address 0 with data = byte → OPB.
  - OPB: rf_wr_en to address 1 with data = byte → ALU_FUN.
  - ALU_FUN: alu_fun = byte[FUN_WIDTH-1:0], alu_en pulse → WAIT_RESP.
  - WAIT_RESP: resp_done → IDLE. rx_valid bytes are dropped without a cmd_err.
- clk_gate_en is high in ALU_FUN, and in WAIT_RESP when entered from ALU_FUN. It is low otherwise.
- rf_addr, rf_wr_data and alu_fun hold their last values between strobes.
- Outputs that are not strobed remain stable. No more than one of rf_wr_en, rf_rd_en and alu_en is high in any cycle.

## Timing
- All outputs are registered. A byte with rx_valid at edge n produces its strobe and the new addr/data/fun values at edge n+1.
- Reset values: all strobes 0, rf_addr 0, rf_wr_data 0, alu_fun 0, clk_gate_en 0, cmd_err 0, busy 0. State is IDLE.
- A reset assertion mid-frame returns the block to IDLE immediately. The partial frame is discarded.
- Back-to-back rx_valid pulses on consecutive cycles are each accepted.
- resp_done and rx_valid in the same cycle in WAIT_RESP: resp_done wins and the byte is dropped.
- resp_done outside WAIT_RESP is ignored.
- busy rises on the edge that enters WAIT_RESP. It falls on the edge after resp_done.

## Configuration
- CMD_TIMEOUT_EN defined:
  - A 16-bit idle counter runs in WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB and ALU_FUN. It clears on every accepted byte.
  - When the counter reaches TIMEOUT_CYCLES, the block returns to IDLE on the next edge and pulses cmd_err. No strobe is issued.
  - IDLE and WAIT_RESP are never timed out.
- CMD_TIMEOUT_EN undefined: no counter is present, and a partial frame waits indefinitely.

## Test plan
- Write then read: feed 0xAA, 0x0A, 0x89. Expect one rf_wr_en with rf_addr=0xA and rf_wr_data=0x89, then IDLE. Feed 0xBB, 0x0A. Expect rf_rd_en with rf_addr=0xA and busy=1; busy=0 one cycle after resp_done.
- ALU with operands: feed 0xCC, 0xFF, 0xAA, 0x04. Expect a write of 0xFF to address 0, a write of 0xAA to address 1, then alu_en with alu_fun=4. clk_gate_en is high from ALU_FUN until resp_done.
- ALU without operands: feed 0xDD, 0x02. Expect no rf_wr_en and alu_en with alu_fun=2.
- Error and drop cases:
  - Unknown byte 0x55 in IDLE gives a cmd_err pulse, with no strobes and the state unchanged.
  - A byte 0x01 received in WAIT_RESP is dropped.
  - A following 0xDD, 0x01 after resp_done gives alu_en with alu_fun=1.
- Reset mid-frame: feed 0xAA, 0x03, then assert rst low for 1 cycle, then feed 0x77. Expect no rf_wr_en and 0x77 treated as an unknown command, giving cmd_err.
- With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=100: feed 0xCC, then wait 100 cycles. Expect a cmd_err pulse and a return to IDLE. A following 0xBB, 0x05 gives rf_rd_en with rf_addr=5.
